// File: rtl/io_input_reg_if.sv
// CPU-side read port of the switch/key input block.
// addr and read_io_enable describe the current cycle's access; io_read_data answers combinationally.
interface io_input_reg_if;
  logic [31:0] addr;
  logic        read_io_enable;
  logic [31:0] io_read_data;

  modport master (output addr, output read_io_enable, input io_read_data);
  modport slave  (input addr, input read_io_enable, output io_read_data);
endinterface

// File: rtl/io_input_reg.sv
// Memory-mapped input register block: synchronized slide switches, debounced pushbuttons
// with sticky press events and a press counter, read at C0h..CCh.
module io_input_reg #(
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic         io_clk,
  input  logic         clrn,
  input  logic [9:0]   sw,
  input  logic [3:0]   key,
  io_input_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  localparam logic [5:0] A_SW  = 6'b110000;
  localparam logic [5:0] A_DB  = 6'b110001;
  localparam logic [5:0] A_EVT = 6'b110010;
  localparam logic [5:0] A_CNT = 6'b110011;

  logic [9:0]       sw_s1, sw_s2, sw_q;
  logic [3:0]       key_s1, key_s2;
  logic [3:0]       ks;
  logic [3:0]       db, db_nxt, rise, evt;
  logic [7:0]       press_cnt, rise_cnt;
  logic [CNT_W-1:0] cnt [4];
  logic             evt_clr;
  logic [5:0]       word;
  logic             unused_addr_bits;

  assign word             = bus.addr[7:2];
  assign unused_addr_bits = ^{bus.addr[31:8], bus.addr[1:0]};
  assign ks               = ~key_s2;
  // The read strobe has one side effect: clearing evt at the edge ending a C8h read.
  assign evt_clr          = bus.read_io_enable && (word == A_EVT);

  always_comb begin
    db_nxt = db;
    for (int i = 0; i < 4; i++) begin
      if ((ks[i] != db[i]) && (cnt[i] == DB_LAST)) db_nxt[i] = ~db[i];
    end
  end

  assign rise     = db_nxt & ~db;
  assign rise_cnt = {7'b0, rise[0]} + {7'b0, rise[1]} + {7'b0, rise[2]} + {7'b0, rise[3]};

  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      sw_s1     <= '0;
      sw_s2     <= '0;
      sw_q      <= '0;
      key_s1    <= '1;
      key_s2    <= '1;
      db        <= '0;
      evt       <= '0;
      press_cnt <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      sw_q   <= sw_s2;
      key_s1 <= key;
      key_s2 <= key_s1;
      for (int i = 0; i < 4; i++) begin
        if (ks[i] == db[i])        cnt[i] <= '0;
        else if (cnt[i] == DB_LAST) cnt[i] <= '0;
        else                        cnt[i] <= cnt[i] + 1'b1;
      end
      db        <= db_nxt;
      // A bit rising on the clearing edge survives the clear.
      evt       <= (evt_clr ? 4'b0 : evt) | rise;
      press_cnt <= press_cnt + rise_cnt;
    end
  end

  always_comb begin
    bus.io_read_data = 32'b0;
    case (word)
      A_SW:    bus.io_read_data = {22'b0, sw_q};
      A_DB:    bus.io_read_data = {28'b0, db};
      A_EVT:   bus.io_read_data = {28'b0, evt};
      A_CNT:   bus.io_read_data = {24'b0, press_cnt};
      default: bus.io_read_data = 32'b0;
    endcase
  end

endmodule

// File: tb/tb_io_input_reg.sv
// Bench for io_input_reg with a short debounce window: vector table, directed corner
// sequences, and randomized traffic against a sliding-window reference model.
module tb_io_input_reg;
  localparam int DB = 4;

  logic       io_clk = 1'b0;
  logic       clrn   = 1'b0;
  logic [9:0] sw     = '0;
  logic [3:0] key    = 4'hF;

  io_input_reg_if bus ();

  io_input_reg #(.DB_CYCLES(DB), .CNT_W(16)) dut (
    .io_clk (io_clk),
    .clrn   (clrn),
    .sw     (sw),
    .key    (key),
    .bus    (bus)
  );

  always #5 io_clk = ~io_clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: delay lines for the synchronizers, last DB synchronized key
  // samples as a window; a key level flips once the whole window disagrees with it.
  logic [9:0] m_sd1, m_sd2, m_swq;
  logic [3:0] m_kd1, m_kd2, m_db, m_evt;
  logic [7:0] m_pc;
  logic [3:0] m_win[$];

  task automatic model_reset();
    m_sd1 = '0; m_sd2 = '0; m_swq = '0;
    m_kd1 = 4'hF; m_kd2 = 4'hF;
    m_db = '0; m_evt = '0; m_pc = '0;
    m_win.delete();
  endtask

  task automatic model_step(input logic [9:0] sw_i, input logic [3:0] key_i,
                            input logic [31:0] a, input logic r);
    logic [3:0] ks, nd, rise;
    bit all_diff;
    ks = ~m_kd2;
    m_win.push_back(ks);
    if (m_win.size() > DB) void'(m_win.pop_front());
    nd = m_db;
    for (int i = 0; i < 4; i++) begin
      if (m_win.size() == DB) begin
        all_diff = 1'b1;
        foreach (m_win[j]) if (m_win[j][i] == m_db[i]) all_diff = 1'b0;
        if (all_diff) nd[i] = ~m_db[i];
      end
    end
    rise = nd & ~m_db;
    if (r && a[7:2] == 6'h32) m_evt = '0;
    m_evt = m_evt | rise;
    m_pc  = m_pc + 8'($countones(rise));
    m_db  = nd;
    m_swq = m_sd2; m_sd2 = m_sd1; m_sd1 = sw_i;
    m_kd2 = m_kd1; m_kd1 = key_i;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a[7:2])
      6'h30:   return {22'b0, m_swq};
      6'h31:   return {28'b0, m_db};
      6'h32:   return {28'b0, m_evt};
      6'h33:   return {24'b0, m_pc};
      default: return 32'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge io_clk);
    @(negedge io_clk);
  endtask

  task automatic set_bus(input logic [31:0] a, input logic r);
    bus.addr = a;
    bus.read_io_enable = r;
  endtask

  // Entered and left at a falling edge; checks that every mapped address reads 0 at once.
  task automatic do_reset();
    clrn = 1'b0;
    set_bus(32'hC0, 1'b0); #1 check("rst_c0", bus.io_read_data, 32'h0);
    set_bus(32'hC4, 1'b0); #1 check("rst_c4", bus.io_read_data, 32'h0);
    set_bus(32'hC8, 1'b0); #1 check("rst_c8", bus.io_read_data, 32'h0);
    set_bus(32'hCC, 1'b0); #1 check("rst_cc", bus.io_read_data, 32'h0);
    @(posedge io_clk);
    @(negedge io_clk);
    clrn = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [9:0]  sw;
    logic [3:0]  key;
    logic [31:0] addr;
    logic        ren;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [9:0] s, input logic [3:0] k, input logic [31:0] a,
                     input logic r, input logic [31:0] e, input string n);
    vec_t v;
    v.sw = s; v.key = k; v.addr = a; v.ren = r; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] r32;
    logic [31:0] a_r;
    logic [5:0]  w_r;
    logic [9:0]  sw_r;
    logic [3:0]  key_r;
    logic        ren_r;

    set_bus(32'h0, 1'b0);
    @(negedge io_clk);
    do_reset();

    // Expected value is read just after each vector's clock edge.
    add(10'h2A5, 4'hF, 32'hC0, 0, 32'h0,   "sw_edge1");
    add(10'h2A5, 4'hF, 32'hC0, 0, 32'h0,   "sw_edge2");
    add(10'h2A5, 4'hF, 32'hC0, 0, 32'h2A5, "sw_edge3");
    for (int i = 0; i < 3; i++) add(10'h2A5, 4'hD, 32'hC4, 0, 32'h0, "glitch_low");
    add(10'h2A5, 4'hF, 32'hC4, 0, 32'h0, "glitch_db");
    add(10'h2A5, 4'hF, 32'hC8, 0, 32'h0, "glitch_evt");
    add(10'h2A5, 4'hF, 32'hCC, 0, 32'h0, "glitch_cnt");
    add(10'h2A5, 4'hF, 32'hC4, 0, 32'h0, "glitch_db2");
    for (int i = 0; i < 5; i++) add(10'h2A5, 4'hD, 32'hC4, 0, 32'h0, "hold_wait");
    add(10'h2A5, 4'hD, 32'hC4, 0, 32'h2,   "hold_db");
    add(10'h2A5, 4'hD, 32'hC8, 0, 32'h2,   "hold_evt");
    add(10'h2A5, 4'hD, 32'hCC, 0, 32'h1,   "hold_cnt");
    add(10'h2A5, 4'hD, 32'h9C, 1, 32'h0,   "unmapped");
    add(10'h2A5, 4'hD, 32'hC0, 1, 32'h2A5, "sw_kept");

    foreach (vecs[i]) begin
      sw = vecs[i].sw;
      key = vecs[i].key;
      set_bus(vecs[i].addr, vecs[i].ren);
      tick();
      check(vecs[i].name, bus.io_read_data, vecs[i].exp);
    end

    // Clear-on-read returns the old value, then zero.
    set_bus(32'hC8, 1'b1); #1 check("evt_pre_clear", bus.io_read_data, 32'h2);
    tick();
    set_bus(32'hC8, 1'b0); #1 check("evt_cleared", bus.io_read_data, 32'h0);
    set_bus(32'hC4, 1'b0); #1 check("db_after_clear", bus.io_read_data, 32'h2);

    // key[0] rises on the very edge that clears evt.
    key = 4'hC;
    set_bus(32'hC8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("evt_k0_wait", bus.io_read_data, 32'h0);
    end
    set_bus(32'hC8, 1'b1); #1 check("evt_pre_clear2", bus.io_read_data, 32'h0);
    tick();
    set_bus(32'hC8, 1'b0); #1 check("evt_set_wins", bus.io_read_data, 32'h1);
    set_bus(32'hCC, 1'b0); #1 check("cnt_two", bus.io_read_data, 32'h2);

    // Reset in the middle of a key[2] debounce window.
    key = 4'hB;
    tick();
    tick();
    do_reset();
    set_bus(32'hC8, 1'b0);
    for (int i = 0; i < DB + 1; i++) begin
      tick();
      check("rst_db_wait", bus.io_read_data, 32'h0);
    end
    tick();
    check("rst_db_evt", bus.io_read_data, 32'h4);
    key = 4'hF;

    // 256 presses of key[0]: counter wraps, unmapped address stays zero.
    do_reset();
    for (int p = 0; p < 256; p++) begin
      key = 4'hE;
      for (int c = 0; c < DB + 3; c++) tick();
      key = 4'hF;
      for (int c = 0; c < DB + 3; c++) tick();
      set_bus(32'hCC, 1'b0); #1 check("press_cnt", bus.io_read_data, 32'((p + 1) % 256));
      set_bus(32'h9C, 1'b1); #1 check("unmapped_9c", bus.io_read_data, 32'h0);
    end

    // Randomized traffic against the model, with occasional resets.
    do_reset();
    sw_r = '0;
    key_r = 4'hF;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 400) == 0) begin
        do_reset();
      end
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 9) == 0) key_r[i] = ~key_r[i];
      if ($urandom_range(0, 15) == 0) sw_r = 10'($urandom);
      r32 = $urandom;
      case ($urandom_range(0, 5))
        0:       w_r = 6'h30;
        1:       w_r = 6'h31;
        2:       w_r = 6'h32;
        3:       w_r = 6'h33;
        4:       w_r = 6'h27;
        default: w_r = r32[7:2];
      endcase
      a_r   = {r32[31:8], w_r, r32[1:0]};
      ren_r = 1'($urandom_range(0, 1));
      sw = sw_r;
      key = key_r;
      set_bus(a_r, ren_r);
      @(posedge io_clk);
      model_step(sw_r, key_r, a_r, ren_r);
      @(negedge io_clk);
      check("rand_read", bus.io_read_data, model_read(a_r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/io_input_reg.md
IO_INPUT_REG -- requirements
Module: io_input_reg

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 50000, giving the debounce stability window in io_clk cycles (legal range 2..65535).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the debounce counter width.
REQ-003 io_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 clrn  input  1  reset, asynchronous, active-low.
REQ-005 addr  input  32  CPU byte address; only addr[7:2] is decoded.
REQ-006 read_io_enable  input  1  CPU IO read strobe for the current cycle.
REQ-007 sw  input  10  raw slide switches, asynchronous, active-high.
REQ-008 key  input  4  raw pushbuttons, asynchronous, active-low (0 = pressed).
REQ-009 io_read_data  output  32  read data to the CPU.

Function
REQ-010 sw and key SHALL each pass through a two-flop synchronizer before any other use.
REQ-011 The synchronized sw SHALL be registered as sw_q[9:0], with no debounce.
REQ-012 Each key bit i SHALL have its own CNT_W-bit counter and a stable level db[i], where db[i]=1 means pressed.
- ks[i] = inverted synchronized key[i].
REQ-013 Debounce rule, evaluated each cycle for each key bit:
- if ks[i]==db[i]: counter cleared to 0;
- else if counter==DB_CYCLES-1: db[i] toggles and counter cleared;
- else counter increments.
REQ-014 Consequently db[i] SHALL change only after ks[i] has differed from db[i] for DB_CYCLES consecutive cycles.
- Any glitch shorter than DB_CYCLES restarts the window.
REQ-015 A 0->1 transition of db[i] SHALL set sticky flag evt[i] on the same edge.
REQ-016 A 0->1 transition of db[i] SHALL also increment the 8-bit counter press_cnt by the number of bits rising that cycle.
- press_cnt wraps modulo 256.
REQ-017 Read map, decoded on addr[7:2]:
- 110000 (C0h) -> {22'b0, sw_q}
- 110001 (C4h) -> {28'b0, db}
- 110010 (C8h) -> {28'b0, evt}
- 110011 (CCh) -> {24'b0, press_cnt}
- any other address -> 32'b0.
REQ-018 io_read_data SHALL be combinational from addr and current register state, independent of read_io_enable.
- Zero-latency read, compatible with the single-cycle CPU.
REQ-019 A clock edge with read_io_enable=1 and addr[7:2]=110010 SHALL clear evt to 0.
- The read in that cycle returns the pre-clear value.
REQ-020 Simultaneous set and clear-on-read of the same evt bit SHALL leave the bit set (set wins); other bits clear.
REQ-021 A read of C0h, C4h or CCh SHALL have no side effect.
REQ-022 A read of C8h with read_io_enable=0 SHALL have no side effect.
REQ-023 Writes are not decoded; the block SHALL ignore all CPU write activity.

Reset
REQ-024 clrn=0 SHALL immediately and asynchronously clear all of the following:
- synchronizer flops for sw to 0;
- synchronizer flops for key to 1 (released);
- sw_q, db, evt, press_cnt, all debounce counters to 0.
REQ-025 With clrn=0, io_read_data SHALL read 0 at every address.
REQ-026 Reset asserted mid-debounce SHALL discard the partial count; after release a full DB_CYCLES window is required again.
REQ-027 A key held pressed through reset release SHALL produce one evt after DB_CYCLES+2 cycles, since db restarts at 0.

Verification (DB_CYCLES=4)
REQ-028 sw=10'h2A5 held -> C0h reads 32'h000002A5 from the 3rd edge after the change; before that it reads the prior value.
REQ-029 key[1] driven low for 3 cycles then high -> db, evt and press_cnt stay 0.
REQ-030 key[1] driven low and held -> C4h reads 32'h2 and C8h reads 32'h2 on cycle 6 (2 sync + 4 window); press_cnt=1.
REQ-031 Read C8h with read_io_enable=1 -> returns 32'h2; the following cycle returns 0.
- Repeat with key[0] rising on the same edge -> next read returns 32'h1.
REQ-032 256 separate key[0] presses -> press_cnt returns to 8'h00; an unmapped address (e.g. 9Ch) reads 0 throughout.
REQ-033 clrn pulsed low while key[2] has been low for 2 cycles -> outputs 0 at once; after release, evt[2] sets only after DB_CYCLES+2 further cycles.
